// File: rtl/ssb_seq_gen.sv
`default_nettype none
// ssb_seq_gen: generates the 38.211 PSS then SSS BPSK sequences as AXI-stream IQ samples.
// Revision 1.0
module ssb_seq_gen #(
  parameter int OUT_DW    = 32,
  parameter int AMPLITUDE = 8191
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [8:0]        N_id_1_i,
  input  logic [1:0]        N_id_2_i,
  input  logic              start_i,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tlast,
  output logic              m_axis_out_tuser,
  output logic              busy_o,
  output logic              error_o
);

  localparam int            c_hw  = OUT_DW / 2;
  localparam logic [c_hw-1:0] c_pos = c_hw'(AMPLITUDE);
  localparam logic [c_hw-1:0] c_neg = c_hw'(-AMPLITUDE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_SEEK = 3'd2,
    S_PSS  = 3'd3,
    S_SSS  = 3'd4
  } state_t;

  state_t           r_state, w_next;
  logic [8:0]       r_nid1;
  logic [1:0]       r_nid2;
  logic [6:0]       r_mp, r_m0, r_m1, r_s, r_seek;
  logic [6:0]       r_pss, r_x0, r_x1;
  logic [6:0]       r_cnt;
  logic [OUT_DW-1:0] r_tdata;
  logic             r_tvalid, r_tlast, r_tuser, r_error;

  logic             w_start_ok, w_gen, w_xfer, w_bit;
  logic [1:0]       w_q;
  logic [6:0]       w_mp, w_m0, w_m1, w_s;

  // Bit k of each LFSR window holds x(i+k); bit 0 is the current output x(i).
  function automatic logic [6:0] f_step_a(input logic [6:0] x);
    return {x[4] ^ x[0], x[6:1]};
  endfunction

  function automatic logic [6:0] f_step_b(input logic [6:0] x);
    return {x[1] ^ x[0], x[6:1]};
  endfunction

  assign w_start_ok = start_i && (N_id_1_i <= 9'd335) && (N_id_2_i != 2'd3);

  assign w_q  = (r_nid1 >= 9'd224) ? 2'd2 : (r_nid1 >= 9'd112) ? 2'd1 : 2'd0;
  assign w_mp = 7'(r_nid2) * 7'd43;
  assign w_m0 = 7'(w_q) * 7'd15 + 7'(r_nid2) * 7'd5;
  assign w_m1 = 7'(r_nid1 - 9'(w_q) * 9'd112);

  always_comb begin
    w_s = w_mp;
    if (w_m0 > w_s) w_s = w_m0;
    if (w_m1 > w_s) w_s = w_m1;
  end

  // r_cnt == 127 in SSS means all samples generated, waiting for the last to drain.
  assign w_gen  = ((r_state == S_PSS) || ((r_state == S_SSS) && (r_cnt != 7'd127)))
                  && (!r_tvalid || m_axis_out_tready);
  assign w_xfer = r_tvalid && m_axis_out_tready;
  assign w_bit  = (r_state == S_PSS) ? r_pss[0] : (r_x0[0] ^ r_x1[0]);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_next = S_CALC;
      S_CALC: w_next = (w_s == 7'd0) ? S_PSS : S_SEEK;
      S_SEEK: if (r_seek == r_s - 7'd1) w_next = S_PSS;
      S_PSS:  if (w_gen && (r_cnt == 7'd126)) w_next = S_SSS;
      S_SSS:  if ((r_cnt == 7'd127) && w_xfer) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_nid1   <= '0;
      r_nid2   <= '0;
      r_mp     <= '0;
      r_m0     <= '0;
      r_m1     <= '0;
      r_s      <= '0;
      r_seek   <= '0;
      r_pss    <= '0;
      r_x0     <= '0;
      r_x1     <= '0;
      r_cnt    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_nid1 <= N_id_1_i;
            r_nid2 <= N_id_2_i;
            r_pss  <= 7'b1110110;
            r_x0   <= 7'b0000001;
            r_x1   <= 7'b0000001;
            r_cnt  <= '0;
          end else if (start_i) begin
            r_error <= 1'b1;
          end
        end
        S_CALC: begin
          r_mp   <= w_mp;
          r_m0   <= w_m0;
          r_m1   <= w_m1;
          r_s    <= w_s;
          r_seek <= '0;
        end
        S_SEEK: begin
          if (r_seek < r_mp) r_pss <= f_step_a(r_pss);
          if (r_seek < r_m0) r_x0  <= f_step_a(r_x0);
          if (r_seek < r_m1) r_x1  <= f_step_b(r_x1);
          r_seek <= r_seek + 7'd1;
        end
        default: ;
      endcase

      if (w_gen) begin
        r_tvalid <= 1'b1;
        r_tdata  <= {{c_hw{1'b0}}, (w_bit ? c_neg : c_pos)};
        r_tlast  <= (r_cnt == 7'd126);
        r_tuser  <= (r_state == S_SSS);
        if (r_state == S_PSS) begin
          r_pss <= f_step_a(r_pss);
          r_cnt <= (r_cnt == 7'd126) ? 7'd0 : r_cnt + 7'd1;
        end else begin
          r_x0  <= f_step_a(r_x0);
          r_x1  <= f_step_b(r_x1);
          r_cnt <= r_cnt + 7'd1;
        end
      end else if (w_xfer) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
    end
  end

  assign m_axis_out_tdata  = r_tdata;
  assign m_axis_out_tvalid = r_tvalid;
  assign m_axis_out_tlast  = r_tlast;
  assign m_axis_out_tuser  = r_tuser;
  assign busy_o            = (r_state != S_IDLE);
  assign error_o           = r_error;

endmodule
`default_nettype wire

// File: doc/ssb_seq_gen.md
Name: ssb_seq_gen

Overview:
Transmit-side counterpart of the PSS/SSS detection chain. For a given N_id_1 and N_id_2 it generates the 38.211 PSS and SSS BPSK sequences and streams them as frequency-domain IQ samples over AXI-stream: 127 PSS samples, then 127 SSS samples. It feeds the SSB resource mapper and IFFT of the test transmitter, and doubles as a golden stimulus source for SSS_detector and PSS_detector benches.

Parameters:
OUT_DW, 32, packed IQ width; real part in [OUT_DW/2-1:0], imag in [OUT_DW-1:OUT_DW/2]
AMPLITUDE, 8191, magnitude of a BPSK symbol, signed, must fit in OUT_DW/2 bits

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
N_id_1_i  in  9  cell group id 0..335, sampled on accepted start
N_id_2_i  in  2  sector id 0..2, sampled on accepted start
start_i  in  1  single-cycle request to generate one PSS+SSS pair
m_axis_out_tdata  out  OUT_DW  IQ sample
m_axis_out_tvalid  out  1  sample valid
m_axis_out_tready  in  1  downstream ready
m_axis_out_tlast  out  1  high on sample 126 of each sequence
m_axis_out_tuser  out  1  0 = PSS sample, 1 = SSS sample
busy_o  out  1  high in every state except IDLE
error_o  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (async assert, sync-safe release): state IDLE; tvalid, tlast, tuser, busy_o, error_o = 0; tdata = 0; all LFSRs and counters cleared. A mid-operation reset aborts immediately with no partial tlast.
- Sequences:
  - PSS: d(n) = 1-2x((n+mP) mod 127), mP = 43*N_id_2. Recurrence x(i+7) = x(i+4) xor x(i). Init x(6..0) = 1110110.
  - SSS: d(n) = (1-2x0((n+m0) mod 127)) * (1-2x1((n+m1) mod 127)), m0 = 15*floor(N_id_1/112) + 5*N_id_2, m1 = N_id_1 mod 112. Recurrences x0(i+7) = x0(i+4) xor x0(i) and x1(i+7) = x1(i+1) xor x1(i). Init for both: x(0) = 1, x(1..6) = 0.
- Arithmetic: floor(N_id_1/112) is computed by comparing against 112 and 224; no divider. Modulo wrap comes for free from the 127 period of the LFSRs.
- Output mapping: symbol +1 -> real = +AMPLITUDE; symbol -1 -> real = -AMPLITUDE (two's complement). Imag is always 0.
- FSM IDLE -> CALC -> SEEK -> PSS -> SSS -> IDLE:
  - IDLE: start_i accepted only here. If N_id_1_i > 335 or N_id_2_i == 3, pulse error_o and stay in IDLE. Otherwise latch the ids, load the init states, go to CALC.
  - CALC (1 cycle): compute mP, m0, m1 into registers.
  - SEEK: the PSS, x0 and x1 LFSRs each step once per cycle until each has stepped its own offset count. SEEK lasts S = max(mP, m0, m1) cycles; S = 0 skips the state.
  - PSS: emit 127 samples with tuser = 0; the 127th carries tlast.
  - SSS: emit 127 samples with tuser = 1; the 127th carries tlast; then return to IDLE.
- Latency: first tvalid rises 2+S cycles after the clock edge that accepted start_i. With tready held high, output is 254 back-to-back samples and there is no gap between the PSS and SSS sequences.
- Handshake:
  - LFSRs and the sample counter advance only on tvalid && tready.
  - tdata, tlast and tuser stay stable while tvalid && !tready.
  - tvalid never drops mid-sequence.
- start_i while busy_o is high is ignored with no error pulse. The id inputs may change freely after acceptance.

Test Plan:
- N_id_2=0, N_id_1=0, tready=1 -> tvalid at cycle start+2. PSS real[0..6] = +8191, -8191, -8191, +8191, -8191, -8191, -8191 (-8191 = 16'hE001). Imag = 0. tlast on samples 126 and 253.
- Any valid ids -> sum of the 127 PSS real values = -8191 (64 minus-ones, 63 plus-ones). SSS for N_id_1=0, N_id_2=0 -> samples 0..6 all = +8191.
- N_id_2=1, N_id_1=335 -> mP=43, m0=35, m1=111, S=111, first tvalid at start+113. SSS stream bit-exact against the Python reference model used for SSS_detector.
- Random tready backpressure (~50%) -> output sequence identical to the tready=1 run; tdata stable while stalled; exactly 254 transfers.
- start_i with N_id_1=336, and separately N_id_2=3 -> error_o pulses 1 cycle, busy_o stays 0, no tvalid. Second start_i pulse during SEEK -> ignored, single 254-sample burst.
- reset_ni asserted mid-PSS at sample 50 -> tvalid, busy_o and tlast fall asynchronously. A new start after release produces a full correct 254-sample burst.
